// File: rtl/fir_rrc_seq.sv
// fir_rrc_seq: sequencer for the fixed 20-tap RRC FIR datapath.
// Holds the filter in reset while idle, primes it, decimates its output by DECIM
// (keeping index PHASE of each group) and presents kept samples through a
// 2-entry ready/valid FIFO. Reports sticky underrun/overflow.
// Optional: define FIR_RRC_SEQ_STATS_EN to build saturating drop/underrun counters;
// otherwise drop_count and underrun_count are tied to zero.
module fir_rrc_seq #(
    parameter int unsigned LATENCY  = 19,
    parameter int unsigned DECIM    = 4,
    parameter int unsigned PHASE    = 0,
    parameter int unsigned SAMPLE_W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                in_ready,
    output logic                fir_rst,
    output logic [SAMPLE_W-1:0] fir_in,
    input  logic [SAMPLE_W-1:0] fir_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_data,
    output logic                busy,
    output logic                underrun,
    output logic                overflow,
    input  logic                clear_err,
    output logic [15:0]         drop_count,
    output logic [15:0]         underrun_count
);

    localparam int unsigned PW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0] PrimeLast = PW'(LATENCY - 1);
    localparam logic [DW-1:0] DecLast   = DW'(DECIM - 1);
    localparam logic [DW-1:0] DecPhase  = DW'(PHASE);

    typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] prime_cnt_q, prime_cnt_d;
    logic [DW-1:0] dec_cnt_q, dec_cnt_d;
    logic          underrun_q, underrun_d;
    logic          overflow_q, overflow_d;
    logic          push, underrun_evt;

    logic [SAMPLE_W-1:0] mem_q [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          fifo_cnt_q;
    logic                full, pop, do_push, ovf_evt;

    // Control state, counters and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            prime_cnt_q <= '0;
            dec_cnt_q   <= '0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            dec_cnt_q   <= dec_cnt_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next state, filter drive and decimation push decision.
    always_comb begin
        state_d      = state_q;
        prime_cnt_d  = prime_cnt_q;
        dec_cnt_d    = dec_cnt_q;
        fir_rst      = 1'b1;
        fir_in       = '0;
        in_ready     = 1'b0;
        push         = 1'b0;
        underrun_evt = 1'b0;
        case (state_q)
            StIdle: begin
                prime_cnt_d = '0;
                dec_cnt_d   = '0;
                // The triggering sample stays on the bus and is taken in PRIME.
                if (enable && in_valid) state_d = StPrime;
            end
            StPrime, StRun: begin
                fir_rst  = 1'b0;
                fir_in   = in_data;
                in_ready = in_valid;
                // fir_out is a real filter output on every RUN cycle.
                if (state_q == StRun) push = (dec_cnt_q == DecPhase);
                if (!in_valid || !enable) begin
                    state_d      = StIdle;
                    prime_cnt_d  = '0;
                    dec_cnt_d    = '0;
                    underrun_evt = !in_valid;
                end else if (state_q == StPrime) begin
                    if (prime_cnt_q == PrimeLast) begin
                        state_d     = StRun;
                        prime_cnt_d = '0;
                    end else begin
                        prime_cnt_d = prime_cnt_q + 1'b1;
                    end
                end else begin
                    dec_cnt_d = (dec_cnt_q == DecLast) ? '0 : dec_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

    // FIFO handshake: a push while full only succeeds alongside a pop.
    assign full      = (fifo_cnt_q == 2'd2);
    assign out_valid = (fifo_cnt_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign do_push   = push && (!full || pop);
    assign ovf_evt   = push && full && !pop;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    // Two-entry FIFO storage and pointers; flushed by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= fir_out;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as clear_err wins.
    always_comb begin
        underrun_d = underrun_evt | (underrun_q & ~clear_err);
        overflow_d = ovf_evt | (overflow_q & ~clear_err);
    end

    assign underrun = underrun_q;
    assign overflow = overflow_q;

`ifdef FIR_RRC_SEQ_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d, urun_cnt_q, urun_cnt_d;
    logic [15:0] drop_base, urun_base;

    // Saturating event counters; clear_err restarts them, same-cycle events still count.
    always_comb begin
        drop_base  = clear_err ? 16'd0 : drop_cnt_q;
        urun_base  = clear_err ? 16'd0 : urun_cnt_q;
        drop_cnt_d = drop_base + ((ovf_evt && drop_base != 16'hffff) ? 16'd1 : 16'd0);
        urun_cnt_d = urun_base + ((underrun_evt && urun_base != 16'hffff) ? 16'd1 : 16'd0);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
            urun_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            urun_cnt_q <= urun_cnt_d;
        end
    end

    assign drop_count     = drop_cnt_q;
    assign underrun_count = urun_cnt_q;
`else
    assign drop_count     = 16'd0;
    assign underrun_count = 16'd0;
`endif

endmodule
